// File: rtl/pipe_control.sv
`default_nettype none
// ============================================================================
// Module   : pipe_control
// Brief    : ID decode, ID/EX-EX/MEM-MEM/WB control pipeline, NZVC flags,
//            load-use / CBZ / B.LT hazard stall, ID branch resolve, forwarding.
// Revision : 1.0  initial release
// ============================================================================
module pipe_control #(
    parameter bit         FLAG_FWD = 1'b1,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        id_cbz_zero,
    input  logic        ex_n,
    input  logic        ex_z,
    input  logic        ex_v,
    input  logic        ex_c,
    output logic        reg2loc,
    output logic        br_taken,
    output logic        uncond_br,
    output logic        stall,
    output logic        flush,
    output logic [2:0]  ex_alu_op,
    output logic [1:0]  ex_alu_src,
    output logic        ex_is_movz,
    output logic        ex_set_flag,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_write,
    output logic        mem_read,
    output logic        mem_ze,
    output logic [3:0]  mem_xfer_size,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_rd,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_c
);

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] alu_src;
        logic       is_movz;
        logic       set_flag;
        logic       mem_write;
        logic       mem_read;
        logic       mem_ze;
        logic [3:0] xfer;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    ctrl_t      dec;
    logic       use_rn;
    logic       use_r2;
    logic       is_b;
    logic       is_blt;
    logic       is_cbz;
    logic [4:0] id_rd;
    logic [4:0] id_rn;
    logic [4:0] id_r2;
    logic [4:0] src_rn;
    logic [4:0] src_r2;
    logic       load_use;
    logic       cbz_haz;
    logic       blt_stall;
    logic       blt_cond;
    logic       unused_bits;

    ctrl_t      ex_ctl;
    logic [4:0] ex_rd;
    logic [4:0] ex_rn;
    logic [4:0] ex_r2;
    logic       mem_reg_write;
    logic       mem_to_reg_m;
    logic [4:0] mem_rd;

    assign id_rd       = instr[4:0];
    assign id_rn       = instr[9:5];
    assign unused_bits = ^instr[15:10];

    always_comb begin
        dec     = '0;
        reg2loc = 1'b0;
        use_rn  = 1'b0;
        use_r2  = 1'b0;
        is_b    = 1'b0;
        is_blt  = 1'b0;
        is_cbz  = 1'b0;
        if (instr_valid) begin
            casez (instr[31:21])
                11'b1001000100?: begin  // ADDI
                    dec.alu_op = 3'b010; dec.alu_src = 2'b10; dec.reg_write = 1'b1;
                    use_rn = 1'b1;
                end
                11'b10101011000: begin  // ADDS
                    dec.alu_op = 3'b010; dec.set_flag = 1'b1; reg2loc = 1'b1;
                    use_rn = 1'b1; use_r2 = 1'b1;
                end
                11'b11101011000: begin  // SUBS
                    dec.alu_op = 3'b011; dec.set_flag = 1'b1; reg2loc = 1'b1;
                    use_rn = 1'b1; use_r2 = 1'b1;
                end
                11'b11111000010, 11'b00111000010: begin  // LDUR / LDURB
                    dec.alu_op = 3'b010; dec.alu_src = 2'b01;
                    dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
                    dec.xfer   = instr[31] ? 4'b1000 : 4'b0001;
                    dec.mem_ze = ~instr[31];
                    use_rn = 1'b1;
                end
                11'b11111000000, 11'b00111000000: begin  // STUR / STURB
                    dec.alu_op = 3'b010; dec.alu_src = 2'b01; dec.mem_write = 1'b1;
                    dec.xfer   = instr[31] ? 4'b1000 : 4'b0001;
                    use_rn = 1'b1; use_r2 = 1'b1;
                end
                11'b110100101??: begin  // MOVZ
                    dec.alu_src = 2'b11; dec.is_movz = 1'b1; dec.reg_write = 1'b1;
                end
                11'b111100101??: begin  // MOVK keeps the old Rd bits
                    dec.alu_src = 2'b11; dec.reg_write = 1'b1;
                    use_r2 = 1'b1;
                end
                11'b000101?????: is_b   = 1'b1;
                11'b01010100???: is_blt = (instr[4:0] == 5'b01011);
                11'b10110100???: begin
                    is_cbz = 1'b1;
                    use_r2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Unused sources collapse onto the zero register so they never match.
    assign id_r2  = reg2loc ? instr[20:16] : id_rd;
    assign src_rn = use_rn ? id_rn : ZERO_REG;
    assign src_r2 = use_r2 ? id_r2 : ZERO_REG;

    assign load_use  = ex_ctl.mem_read && (ex_rd != ZERO_REG) &&
                       ((src_rn == ex_rd) || (src_r2 == ex_rd));
    assign cbz_haz   = is_cbz && (id_rd != ZERO_REG) &&
                       ((ex_ctl.reg_write && (ex_rd == id_rd)) ||
                        (mem_read && (mem_rd == id_rd)));
    assign blt_stall = is_blt && ex_ctl.set_flag && !FLAG_FWD;
    assign blt_cond  = (ex_ctl.set_flag && FLAG_FWD) ? (ex_n ^ ex_v) : (flag_n ^ flag_v);

    assign stall     = load_use | cbz_haz | blt_stall;
    assign uncond_br = is_b;
    assign br_taken  = !stall && (is_b || (is_blt && blt_cond) || (is_cbz && id_cbz_zero));
    assign flush     = br_taken & ~stall;

    assign ex_alu_op   = ex_ctl.alu_op;
    assign ex_alu_src  = ex_ctl.alu_src;
    assign ex_is_movz  = ex_ctl.is_movz;
    assign ex_set_flag = ex_ctl.set_flag;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd
    );
        if (src == ZERO_REG)             return 2'b00;
        else if (m_we && (m_rd == src))  return 2'b01;
        else if (w_we && (w_rd == src))  return 2'b10;
        else                             return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(ex_rn, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    assign fwd_b = fwd_sel(ex_r2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctl        <= '0;
            ex_rd         <= '0;
            ex_rn         <= ZERO_REG;
            ex_r2         <= ZERO_REG;
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            mem_ze        <= 1'b0;
            mem_xfer_size <= '0;
            mem_reg_write <= 1'b0;
            mem_to_reg_m  <= 1'b0;
            mem_rd        <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            flag_n        <= 1'b0;
            flag_z        <= 1'b0;
            flag_v        <= 1'b0;
            flag_c        <= 1'b0;
        end else begin
            if (stall) begin
                ex_ctl <= '0;
                ex_rd  <= '0;
                ex_rn  <= ZERO_REG;
                ex_r2  <= ZERO_REG;
            end else begin
                ex_ctl <= dec;
                ex_rd  <= id_rd;
                ex_rn  <= src_rn;
                ex_r2  <= src_r2;
            end
            mem_write     <= ex_ctl.mem_write;
            mem_read      <= ex_ctl.mem_read;
            mem_ze        <= ex_ctl.mem_ze;
            mem_xfer_size <= ex_ctl.xfer;
            mem_reg_write <= ex_ctl.reg_write;
            mem_to_reg_m  <= ex_ctl.mem_to_reg;
            mem_rd        <= ex_rd;
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_to_reg_m;
            wb_rd         <= mem_rd;
            if (ex_ctl.set_flag) begin
                flag_n <= ex_n;
                flag_z <= ex_z;
                flag_v <= ex_v;
                flag_c <= ex_c;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_control
// Brief    : Directed self-checking bench for pipe_control (both FLAG_FWD modes).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        id_cbz_zero;
    logic        ex_n, ex_z, ex_v, ex_c;

    logic        reg2loc, br_taken, uncond_br, stall, flush;
    logic [2:0]  ex_alu_op;
    logic [1:0]  ex_alu_src;
    logic        ex_is_movz, ex_set_flag;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_write, mem_read, mem_ze;
    logic [3:0]  mem_xfer_size;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic        flag_n, flag_z, flag_v, flag_c;

    logic        f0_reg2loc, f0_br_taken, f0_uncond_br, f0_stall, f0_flush;
    logic [2:0]  f0_ex_alu_op;
    logic [1:0]  f0_ex_alu_src;
    logic        f0_ex_is_movz, f0_ex_set_flag;
    logic [1:0]  f0_fwd_a, f0_fwd_b;
    logic        f0_mem_write, f0_mem_read, f0_mem_ze;
    logic [3:0]  f0_mem_xfer_size;
    logic        f0_wb_reg_write, f0_wb_mem_to_reg;
    logic [4:0]  f0_wb_rd;
    logic        f0_flag_n, f0_flag_z, f0_flag_v, f0_flag_c;

    logic [4:0]  idv, f0_idv;
    logic [6:0]  exv;
    logic [3:0]  flags;
    assign idv    = {reg2loc, br_taken, uncond_br, stall, flush};
    assign f0_idv = {f0_reg2loc, f0_br_taken, f0_uncond_br, f0_stall, f0_flush};
    assign exv    = {ex_alu_op, ex_alu_src, ex_is_movz, ex_set_flag};
    assign flags  = {flag_n, flag_z, flag_v, flag_c};

    always #5 clk = ~clk;

    pipe_control #(.FLAG_FWD(1'b1), .ZERO_REG(5'd31)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .id_cbz_zero(id_cbz_zero), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v), .ex_c(ex_c),
        .reg2loc(reg2loc), .br_taken(br_taken), .uncond_br(uncond_br),
        .stall(stall), .flush(flush), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_is_movz(ex_is_movz), .ex_set_flag(ex_set_flag), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_write(mem_write), .mem_read(mem_read), .mem_ze(mem_ze),
        .mem_xfer_size(mem_xfer_size), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
    );

    pipe_control #(.FLAG_FWD(1'b0), .ZERO_REG(5'd31)) dut0 (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .id_cbz_zero(id_cbz_zero), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v), .ex_c(ex_c),
        .reg2loc(f0_reg2loc), .br_taken(f0_br_taken), .uncond_br(f0_uncond_br),
        .stall(f0_stall), .flush(f0_flush), .ex_alu_op(f0_ex_alu_op),
        .ex_alu_src(f0_ex_alu_src), .ex_is_movz(f0_ex_is_movz),
        .ex_set_flag(f0_ex_set_flag), .fwd_a(f0_fwd_a), .fwd_b(f0_fwd_b),
        .mem_write(f0_mem_write), .mem_read(f0_mem_read), .mem_ze(f0_mem_ze),
        .mem_xfer_size(f0_mem_xfer_size), .wb_reg_write(f0_wb_reg_write),
        .wb_mem_to_reg(f0_wb_mem_to_reg), .wb_rd(f0_wb_rd),
        .flag_n(f0_flag_n), .flag_z(f0_flag_z), .flag_v(f0_flag_v), .flag_c(f0_flag_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
        return {10'b1001000100, imm, rn, rd};
    endfunction
    function automatic logic [31:0] e_adds(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'b10101011000, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] e_subs(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'b11101011000, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] e_ldur(input logic [4:0] rt, input logic [4:0] rn);
        return {11'b11111000010, 9'd0, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] e_movz(input logic [4:0] rd, input logic [15:0] imm);
        return {9'b110100101, 2'b00, imm, rd};
    endfunction
    function automatic logic [31:0] e_b(input logic [25:0] off);
        return {6'b000101, off};
    endfunction
    function automatic logic [31:0] e_blt(input logic [18:0] off);
        return {8'b01010100, off, 5'b01011};
    endfunction
    function automatic logic [31:0] e_cbz(input logic [4:0] rt, input logic [18:0] off);
        return {8'b10110100, off, rt};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] i);
        instr       = i;
        instr_valid = 1'b1;
        #1;
    endtask

    task automatic bubble;
        instr_valid = 1'b0;
        #1;
    endtask

    task automatic drain;
        instr_valid = 1'b0;
        repeat (3) tick;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; instr = '0; instr_valid = 1'b0; id_cbz_zero = 1'b0;
        ex_n = 1'b0; ex_z = 1'b0; ex_v = 1'b0; ex_c = 1'b0;
        tick; tick;
        reset = 1'b0;
        #1;
        check("rst_ctl", {ex_alu_op, ex_alu_src, ex_is_movz, ex_set_flag, mem_write, mem_read,
                          mem_ze, mem_xfer_size, wb_reg_write, wb_mem_to_reg, wb_rd}, 32'd0);
        check("rst_flags", flags, 32'd0);
        check("rst_fwd", {fwd_a, fwd_b}, 32'd0);

        // unknown opcode decodes to a NOP
        put(32'h0000_0000);
        check("nop_id", idv, 32'd0);
        tick;
        check("nop_ex", exv, 32'd0);

        put(e_movz(5'd9, 16'd7));
        check("movz_id", idv, 32'd0);
        tick;
        check("movz_ex", exv, {25'd0, 7'b0001110});
        drain;

        // ADDI X1,X0,#5 ; ADDS X2,X1,X1
        put(e_addi(5'd1, 5'd0, 12'd5));
        tick;
        put(e_adds(5'd2, 5'd1, 5'd1));
        check("adds_id", idv, {27'd0, 5'b10000});
        check("addi_ex", exv, {25'd0, 7'b0101000});
        tick;
        ex_z = 1'b1; ex_c = 1'b1;
        bubble;
        check("adds_fwd", {fwd_a, fwd_b}, {28'd0, 4'b0101});
        check("adds_ex", exv, {25'd0, 7'b0100001});
        tick;
        ex_z = 1'b0; ex_c = 1'b0;
        #1;
        check("addi_wb", {wb_reg_write, wb_mem_to_reg, wb_rd}, {25'd0, 7'b1000001});
        check("flags_load", flags, {28'd0, 4'b0101});
        drain;

        // LDUR X3,[X1] ; SUBS X4,X3,X2
        put(e_ldur(5'd3, 5'd1));
        tick;
        put(e_subs(5'd4, 5'd3, 5'd2));
        check("lu_stall", idv, {27'd0, 5'b10010});
        tick;
        check("lu_bubble", exv, 32'd0);
        check("lu_mem", {mem_read, mem_write, mem_ze, mem_xfer_size}, {25'd0, 7'b1001000});
        check("lu_go", idv, {27'd0, 5'b10000});
        tick;
        bubble;
        check("lu_fwd", {fwd_a, fwd_b}, {28'd0, 4'b1000});
        check("lu_wb", {wb_reg_write, wb_mem_to_reg, wb_rd}, {25'd0, 7'b1100011});
        drain;

        // SUBS X5,X1,X2 (N=1,V=0) ; B.LT
        put(e_subs(5'd5, 5'd1, 5'd2));
        tick;
        ex_n = 1'b1; ex_v = 1'b0;
        put(e_blt(19'd4));
        check("blt_fwd1", idv, {27'd0, 5'b01001});
        check("blt_fwd0", f0_idv, {27'd0, 5'b00010});
        tick;
        ex_n = 1'b0;
        #1;
        check("blt_flag0", {f0_flag_n, f0_flag_v}, {30'd0, 2'b10});
        check("blt_late0", f0_idv, {27'd0, 5'b01001});
        drain;

        put(e_b(26'd8));
        check("b_id", idv, {27'd0, 5'b01101});
        drain;

        // LDUR X6 ; CBZ X6 -> two stall cycles
        put(e_ldur(5'd6, 5'd1));
        tick;
        id_cbz_zero = 1'b1;
        put(e_cbz(5'd6, 19'd2));
        check("cbz_st1", idv, {27'd0, 5'b00010});
        tick;
        check("cbz_st2", idv, {27'd0, 5'b00010});
        tick;
        check("cbz_go", idv, {27'd0, 5'b01001});
        id_cbz_zero = 1'b0;
        drain;

        // X31 destination never hazards or forwards
        put(e_ldur(5'd31, 5'd1));
        tick;
        put(e_adds(5'd7, 5'd31, 5'd31));
        check("zr_nostall", idv, {27'd0, 5'b10000});
        tick;
        ex_n = 1'b1; ex_c = 1'b1;
        bubble;
        check("zr_fwd", {fwd_a, fwd_b}, 32'd0);
        tick;
        ex_n = 1'b0; ex_c = 1'b0;
        drain;
        check("flags_pre", flags, {28'd0, 4'b1001});

        // reset while a load sits in MEM
        put(e_ldur(5'd8, 5'd1));
        tick;
        bubble;
        tick;
        check("rm_mem", mem_read, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        check("rm_mem_rd", mem_read, 32'd0);
        check("rm_wb", {wb_reg_write, wb_mem_to_reg, wb_rd}, 32'd0);
        check("rm_flags", flags, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
